// File: rtl/seg_display_scan_if.sv
// ---------------------------------------------------------------------------
// seg_display_scan_if
//   Bundles the value/load side and the display pin side of the
//   seg_display_scan driver so that the driver and its user share one port.
//
//   Signals
//     value       32  display value, digit i = value[4i+3:4i]
//     load         1  single-cycle capture strobe
//     dp_mask      8  per-digit decimal point enable
//     blank_mask   8  per-digit forced blank
//     busy         1  captured value waiting for the next frame boundary
//     frame_done   1  one-cycle pulse after digit 7's slot ends
//     seg_sel      8  active-low digit enables
//     seg_data     8  active-low segments, bit0=a .. bit6=g, bit7=dp
//
//   Modports
//     master : drives value/load/masks, observes the display outputs
//     slave  : the display driver itself
// ---------------------------------------------------------------------------
interface seg_display_scan_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic        busy;
  logic        frame_done;
  logic [7:0]  seg_sel;
  logic [7:0]  seg_data;

  modport master (
    output value,
    output load,
    output dp_mask,
    output blank_mask,
    input  busy,
    input  frame_done,
    input  seg_sel,
    input  seg_data
  );

  modport slave (
    input  value,
    input  load,
    input  dp_mask,
    input  blank_mask,
    output busy,
    output frame_done,
    output seg_sel,
    output seg_data
  );
endinterface

// File: rtl/seg_display_scan.sv
// ---------------------------------------------------------------------------
// seg_display_scan
//   Multiplexed 8-digit 7-segment driver. One digit is lit per slot of
//   SCAN_DIV clocks; the first BLANK_CYCLES clocks of each slot keep every
//   digit deselected so the previous digit's segments cannot ghost onto the
//   next one. A new value is captured on load into a pending buffer and only
//   copied into the displayed (shadow) registers when digit 7's slot ends, so
//   a frame never mixes two values.
//
//   Ports
//     clk    : system clock
//     reset  : synchronous, active-high; clears all state
//     bus    : seg_display_scan_if.slave (value/load/masks in,
//              busy/frame_done/seg_sel/seg_data out, all outputs registered)
//
//   Parameters
//     SCAN_DIV     : clocks per digit slot, 2 .. 2^20
//     BLANK_CYCLES : blanked clocks at the start of each slot, < SCAN_DIV
//     LZ_SUPPRESS  : 1 = blank leading zero digits (digit 0 always shown)
// ---------------------------------------------------------------------------
module seg_display_scan #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          LZ_SUPPRESS  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  seg_display_scan_if.slave   bus
);

  // 20 bits covers the largest legal SCAN_DIV-1 (2^20-1).
  localparam int unsigned   PW          = 20;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);

  // Active-low hex font for segments a..g (bit7/dp is added by the caller).
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Scan counters
  logic [PW-1:0] r_presc;
  logic [2:0]    r_digit;

  // Pending buffer (filled by load) and shadow registers (what is displayed)
  logic [31:0]   r_pend_value;
  logic [7:0]    r_pend_dp;
  logic [7:0]    r_pend_blank;
  logic          r_pending;
  logic [31:0]   r_shadow_value;
  logic [7:0]    r_shadow_dp;
  logic [7:0]    r_shadow_blank;

  // Registered outputs
  logic          r_frame_done;
  logic [7:0]    r_seg_sel;
  logic [7:0]    r_seg_data;

  // Combinational helpers
  logic          w_tick;
  logic          w_wrap;
  logic          w_blank_phase;
  logic [3:0]    w_nibble;
  logic [7:0]    w_zero_from;
  logic          w_zero_acc;
  logic [7:0]    w_sel;
  logic [7:0]    w_seg_code;

  assign w_tick        = (r_presc == PRESC_LAST);
  assign w_wrap        = w_tick && (r_digit == 3'd7);
  assign w_blank_phase = (r_presc < PRESC_BLANK);
  assign w_nibble      = r_shadow_value[{r_digit, 2'b00} +: 4];
  assign w_sel         = ~(8'h01 << r_digit);

  // w_zero_from[i] = nibbles i..7 of the shadow value are all zero
  always_comb begin
    w_zero_from = 8'h00;
    w_zero_acc  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      w_zero_acc     = w_zero_acc && (r_shadow_value[i*4 +: 4] == 4'h0);
      w_zero_from[i] = w_zero_acc;
    end
  end

  // Segment pattern for the digit currently being scanned
  always_comb begin
    w_seg_code = 8'hFF;
    if (r_shadow_blank[r_digit]) begin
      w_seg_code = 8'hFF;
    end else if (LZ_SUPPRESS && (r_digit != 3'd0) && w_zero_from[r_digit]) begin
      // Suppressed leading zero keeps its decimal point.
      w_seg_code = {~r_shadow_dp[r_digit], 7'h7F};
    end else begin
      w_seg_code = {~r_shadow_dp[r_digit], hex7(w_nibble)};
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= 20'd0;
      r_digit <= 3'd0;
    end else if (w_tick) begin
      r_presc <= 20'd0;
      r_digit <= r_digit + 3'd1;
    end else begin
      r_presc <= r_presc + 20'd1;
      r_digit <= r_digit;
    end
  end

  // Frame-done pulse on the cycle after the digit-7 tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
    end
  end

  // Load capture into the pending buffer and hand-over to shadow at wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_value   <= 32'h0000_0000;
      r_pend_dp      <= 8'h00;
      r_pend_blank   <= 8'h00;
      r_pending      <= 1'b0;
      r_shadow_value <= 32'h0000_0000;
      r_shadow_dp    <= 8'h00;
      r_shadow_blank <= 8'h00;
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (bus.load) begin
        // A load on the wrap tick bypasses (and discards) the pending buffer.
        r_shadow_value <= bus.value;
        r_shadow_dp    <= bus.dp_mask;
        r_shadow_blank <= bus.blank_mask;
      end else if (r_pending) begin
        r_shadow_value <= r_pend_value;
        r_shadow_dp    <= r_pend_dp;
        r_shadow_blank <= r_pend_blank;
      end else begin
        r_shadow_value <= r_shadow_value;
        r_shadow_dp    <= r_shadow_dp;
        r_shadow_blank <= r_shadow_blank;
      end
    end else if (bus.load) begin
      // Later loads in the same frame overwrite earlier ones.
      r_pend_value <= bus.value;
      r_pend_dp    <= bus.dp_mask;
      r_pend_blank <= bus.blank_mask;
      r_pending    <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // Pin drivers, registered one cycle behind the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg_sel  <= 8'hFF;
      r_seg_data <= 8'hFF;
    end else if (w_blank_phase) begin
      r_seg_sel  <= 8'hFF;
      r_seg_data <= 8'hFF;
    end else begin
      r_seg_sel  <= w_sel;
      r_seg_data <= w_seg_code;
    end
  end

  assign bus.busy       = r_pending;
  assign bus.frame_done = r_frame_done;
  assign bus.seg_sel    = r_seg_sel;
  assign bus.seg_data   = r_seg_data;

endmodule

// File: tb/tb_seg_display_scan.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scan
//   Directed bench for seg_display_scan with SCAN_DIV=4, BLANK_CYCLES=1.
//   Two instances run in lock-step from the same stimulus: u_dut0 without
//   and u_dut1 with leading-zero suppression. After a frame_done sample the
//   next 32 samples are digit 0..7, four samples each, first one blanked.
// ---------------------------------------------------------------------------
module tb_seg_display_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seg_display_scan_if u_if0 ();
  seg_display_scan_if u_if1 ();

  seg_display_scan #(.SCAN_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(u_if0.slave));
  seg_display_scan #(.SCAN_DIV(4), .BLANK_CYCLES(1), .LZ_SUPPRESS(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(u_if1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl,
                       input logic ld);
    u_if0.value = v; u_if0.dp_mask = dp; u_if0.blank_mask = bl; u_if0.load = ld;
    u_if1.value = v; u_if1.dp_mask = dp; u_if1.blank_mask = bl; u_if1.load = ld;
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
    drive(v, dp, bl, 1'b1);
    step();
    drive(v, dp, bl, 1'b0);
  endtask

  // Advance until frame_done is sampled high; a missing pulse is a failure.
  task automatic wait_frame(input string tag);
    for (int n = 0; n < 40; n++) begin
      step();
      if (u_if0.frame_done === 1'b1) break;
    end
    chk({tag, " frame_sync"}, {31'd0, u_if0.frame_done}, 32'd1);
  endtask

  // Check one full 32-cycle frame; exp[8d+:8] is digit d's segment pattern.
  task automatic check_frame(input int which, input logic [63:0] exp, input string tag);
    logic [7:0] one;
    logic [7:0] e_sel, e_dat, o_sel, o_dat;
    logic       o_fd, o_busy;
    one = 8'h01;
    for (int d = 0; d < 8; d++) begin
      for (int p = 0; p < 4; p++) begin
        step();
        if (which == 0) begin
          o_sel = u_if0.seg_sel; o_dat = u_if0.seg_data;
          o_fd  = u_if0.frame_done; o_busy = u_if0.busy;
        end else begin
          o_sel = u_if1.seg_sel; o_dat = u_if1.seg_data;
          o_fd  = u_if1.frame_done; o_busy = u_if1.busy;
        end
        e_sel = (p == 0) ? 8'hFF : ~(one << d);
        e_dat = (p == 0) ? 8'hFF : exp[d*8 +: 8];
        chk($sformatf("%s d%0d p%0d seg_sel", tag, d, p), {24'd0, o_sel}, {24'd0, e_sel});
        chk($sformatf("%s d%0d p%0d seg_data", tag, d, p), {24'd0, o_dat}, {24'd0, e_dat});
        chk($sformatf("%s d%0d p%0d frame_done", tag, d, p), {31'd0, o_fd},
            {31'd0, (d == 7 && p == 3) ? 1'b1 : 1'b0});
        chk($sformatf("%s d%0d p%0d busy", tag, d, p), {31'd0, o_busy}, 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset and free-running scan of zeros
    drive(32'h0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    run_steps(3);
    chk("rst seg_sel", {24'd0, u_if0.seg_sel}, 32'h0000_00FF);
    chk("rst seg_data", {24'd0, u_if0.seg_data}, 32'h0000_00FF);
    chk("rst busy", {31'd0, u_if0.busy}, 32'd0);
    chk("rst frame_done", {31'd0, u_if0.frame_done}, 32'd0);
    reset = 1'b0;
    check_frame(0, {8{8'hC0}}, "t1f0");
    check_frame(0, {8{8'hC0}}, "t1f1");

    // 2. mid-frame load shows up only in the following frame
    run_steps(5);
    pulse_load(32'h0123_ABCD, 8'h04, 8'h00);
    chk("t2 busy_set", {31'd0, u_if0.busy}, 32'd1);
    wait_frame("t2");
    chk("t2 busy_clr", {31'd0, u_if0.busy}, 32'd0);
    check_frame(0, 64'hC0F9A4B0_8803C6A1, "t2");

    // 3. two loads in a frame, then a third exactly on the wrap tick
    run_steps(3);
    pulse_load(32'h1111_1111, 8'h00, 8'h00);
    chk("t3 busy_set", {31'd0, u_if0.busy}, 32'd1);
    run_steps(5);
    pulse_load(32'h2222_2222, 8'h00, 8'h00);
    run_steps(21);
    pulse_load(32'h3333_3333, 8'h00, 8'h00);
    chk("t3 wrap frame_done", {31'd0, u_if0.frame_done}, 32'd1);
    chk("t3 wrap busy", {31'd0, u_if0.busy}, 32'd0);
    check_frame(0, {8{8'hB0}}, "t3");

    // 4. leading-zero suppression with dp on a suppressed digit
    run_steps(5);
    pulse_load(32'h0000_00A0, 8'h80, 8'h00);
    wait_frame("t4");
    check_frame(1, 64'h7FFFFFFF_FFFF88C0, "t4");

    // 5. blank mask on the low four digits
    run_steps(5);
    pulse_load(32'hFFFF_FFFF, 8'h00, 8'h0F);
    wait_frame("t5");
    check_frame(0, 64'h8E8E8E8E_FFFFFFFF, "t5");

    // 6. reset mid-slot of digit 5 with a load pending (and a load during reset)
    run_steps(20);
    pulse_load(32'h8765_4321, 8'hFF, 8'h00);
    chk("t6 busy_set", {31'd0, u_if0.busy}, 32'd1);
    reset = 1'b1;
    drive(32'hAAAA_AAAA, 8'hFF, 8'hFF, 1'b1);
    step();
    chk("t6 rst seg_sel", {24'd0, u_if0.seg_sel}, 32'h0000_00FF);
    chk("t6 rst seg_data", {24'd0, u_if0.seg_data}, 32'h0000_00FF);
    chk("t6 rst busy", {31'd0, u_if0.busy}, 32'd0);
    chk("t6 rst frame_done", {31'd0, u_if0.frame_done}, 32'd0);
    drive(32'hAAAA_AAAA, 8'hFF, 8'hFF, 1'b0);
    step();
    reset = 1'b0;
    check_frame(0, {8{8'hC0}}, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
